fetch_stage: RTL and testbench

Instruction-fetch front end between the instruction port of `Memory` and the decode logic inside `Processor`. It owns the program counter and drives `inst_addr`, captures the combinational `instr` read-out into a small prefetch FIFO, and hands instructions downstream over a valid/ready handshake. It supports control-flow redirects with flush and stops fetching on the halt word `32'hfc000000`.

---
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, prefetches into a small FIFO and
// hands instructions to decode over valid/ready; stops on the halt word.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hfc00_0000,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_addr,
    input  logic [31:0] instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [31:0]     addr_mem_q  [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];

    logic pop;
    logic push;
    logic is_halt;

    assign pop     = (count_q != '0) & if_ready;
    // A full FIFO still takes a new entry when the head leaves in the same cycle.
    assign push    = (state_q == RUN) & ~redirect & ((count_q < CW'(DEPTH)) | pop);
    assign is_halt = (instr == HALT_WORD);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;

        if (redirect) begin
            state_d = RUN;
            pc_d    = redirect_pc & ~32'h0000_0003;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
        end else begin
            if (push) begin
                wr_d = wr_q + AW'(1);
                if (is_halt) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem_q[i]  <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if (push) begin
                addr_mem_q[wr_q]  <= pc_q;
                instr_mem_q[wr_q] <= instr;
            end
        end
    end

    assign inst_addr = pc_q;
    assign if_valid  = (count_q != '0);
    assign if_instr  = instr_mem_q[rd_q];
    assign if_pc     = addr_mem_q[rd_q];
    assign halted    = (state_q == HALT) & (count_q == '0);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, async-reset sequence, then
// randomized traffic checked against a queue-based model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] HALTW = 32'hfc00_0000;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_addr;
    logic [31:0] instr;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    logic        halt_en = 1'b1;
    logic [31:0] halt_addr = 32'h0000_000c;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .HALT_WORD(HALTW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .inst_addr  (inst_addr),
        .instr      (instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Memory contents: 0x11, 0x22, 0x33 ... at 0, 4, 8 ..., with one halt slot.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] k;
        k = (a >> 2) + 32'd1;
        return k * 32'd17;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic hen,
                                           input logic [31:0] ha);
        return (hen && a == ha) ? HALTW : word_at(a);
    endfunction

    always_comb instr = mem_rd(inst_addr, halt_en, halt_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_halted;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic rdy,
                                input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei,
                                input logic eh);
        vec_t v;
        v.redirect = r;  v.rpc = rpc;   v.ready = rdy;
        v.e_addr = ea;   v.e_valid = ev; v.e_pc = ep;
        v.e_instr = ei;  v.e_halted = eh;
        return v;
    endfunction

    // Model state
    logic [63:0] mq[$];
    logic [31:0] m_pc;
    logic        m_halt;

    task automatic model_step(input logic r, input logic [31:0] rpc, input logic rdy);
        logic        p, u;
        logic [31:0] w;
        w = mem_rd(m_pc, halt_en, halt_addr);
        p = (mq.size() != 0) && rdy;
        u = !m_halt && !r && ((mq.size() < DEPTH) || p);
        if (r) begin
            mq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            if (p) void'(mq.pop_front());
            if (u) begin
                mq.push_back({m_pc, w});
                if (w == HALTW) m_halt = 1'b1;
                else m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic model_check();
        chk("rnd_addr", inst_addr, m_pc);
        chk("rnd_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
        chk("rnd_halted", {31'd0, halted}, {31'd0, m_halt && mq.size() == 0});
        if (mq.size() != 0) begin
            chk("rnd_pc", if_pc, mq[0][63:32]);
            chk("rnd_instr", if_instr, mq[0][31:0]);
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Streaming, halt at 0xC, redirect out of halt.
        tbl.push_back(mk(0, 0, 1, 32'h4, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 1, 32'h8, 1, 32'h4, 32'h22, 0));
        tbl.push_back(mk(0, 0, 1, 32'hc, 1, 32'h8, 32'h33, 0));
        tbl.push_back(mk(0, 0, 1, 32'hc, 1, 32'hc, HALTW, 0));
        tbl.push_back(mk(0, 0, 1, 32'hc, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 32'hc, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 32'h0, 0, 0, 0, 0));
        // Backpressure for five cycles, then release.
        tbl.push_back(mk(0, 0, 0, 32'h4, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0, 32'h8, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0, 32'h8, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0, 32'h8, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0, 32'h8, 1, 32'h0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 1, 32'hc, 1, 32'h4, 32'h22, 0));
        // Redirect while full with a same-cycle pop.
        tbl.push_back(mk(1, 32'h103, 1, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h104, 1, 32'h100, word_at(32'h100), 0));
        // PC wrap.
        tbl.push_back(mk(1, 32'hffff_fffc, 1, 32'hffff_fffc, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 32'h0, 1, 32'hffff_fffc, word_at(32'hffff_fffc), 0));
        tbl.push_back(mk(0, 0, 0, 32'h4, 1, 32'hffff_fffc, word_at(32'hffff_fffc), 0));
        tbl.push_back(mk(0, 0, 0, 32'h4, 1, 32'hffff_fffc, word_at(32'hffff_fffc), 0));

        #1;
        chk("rst_addr", inst_addr, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);

        foreach (tbl[i]) begin
            redirect    = tbl[i].redirect;
            redirect_pc = tbl[i].rpc;
            if_ready    = tbl[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_addr", i), inst_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].e_halted});
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("v%0d_instr", i), if_instr, tbl[i].e_instr);
            end
        end
        redirect = 1'b0;

        // Async reset with two entries queued, between edges.
        #2 reset = 1'b1;
        #1;
        chk("arst_addr", inst_addr, 32'h0);
        chk("arst_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_instr", if_instr, 32'h0);
        @(negedge clk);
        chk("arst_hold_addr", inst_addr, 32'h0);

        // Async reset while halted.
        reset = 1'b0;
        if_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("pre_arst_halted", {31'd0, halted}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_addr2", inst_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model.
        halt_addr = 32'h0000_0040;
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [31:0] rpc;
            logic        rdy;
            r   = ($urandom_range(0, 99) < 8);
            rpc = ($urandom_range(0, 9) == 0) ? (32'hffff_fff0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 127));
            rdy = ($urandom_range(0, 99) < 65);
            redirect    = r;
            redirect_pc = rpc;
            if_ready    = rdy;
            model_step(r, rpc, rdy);
            @(negedge clk);
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
